bl_row_assembler: RTL

Parametrised successor to the bitline driver. It collects narrow weight beats from the bus side into full-width bitline rows for the PIM macro. Completed rows go into a 2-entry ping-pong store, so the next row can be loaded while the previous one waits for the macro. Both sides use valid/ready handshakes, with selectable beat order and an abort/restart control.

---
 rtl/bl_row_assembler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bl_row_assembler.sv
// bl_row_assembler
//   Collects DATA_W-wide weight beats into ROW_W-wide bitline rows for the
//   PIM macro. Finished rows go into a two-bank ping-pong store, so one row
//   can fill while the other waits for the macro.
//
// Ports
//   CLK          clock, rising edge
//   RSTN         asynchronous active-low reset
//   i_start      drop the partial row, clear the fill bank, restart at beat 0
//   i_lsb_first  beat order; sampled on beat 0 and held for the whole row
//   i_valid      beat valid          / o_ready      beat can be accepted
//   i_data       beat data
//   o_row_valid  row presented       / i_row_ready  macro consumes the row
//   o_row_data   presented row, driven directly from bank flops
//   o_beat_cnt   beats already written into the partial row
//   o_level      completed rows stored (0..2)
module bl_row_assembler #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 256
) (
    input  logic                             CLK,
    input  logic                             RSTN,
    input  logic                             i_start,
    input  logic                             i_lsb_first,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [DATA_W-1:0]                i_data,
    output logic                             o_row_valid,
    input  logic                             i_row_ready,
    output logic [ROW_W-1:0]                 o_row_data,
    output logic [$clog2(ROW_W/DATA_W)-1:0]  o_beat_cnt,
    output logic [1:0]                       o_level
);

    localparam int BEATS = ROW_W / DATA_W;
    localparam int CNT_W = $clog2(BEATS);

    logic [ROW_W-1:0] r_bank [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_order;
    logic [1:0]       r_level;

    logic             w_accept;
    logic             w_pop;
    logic             w_start;
    logic             w_complete;
    logic [CNT_W-1:0] w_slot;
    logic             w_order;
    logic [CNT_W-1:0] w_pos;
    logic [ROW_W-1:0] w_bank_nxt [2];

    assign o_ready     = (r_level != 2'd2);
    assign o_row_valid = (r_level != 2'd0);
    assign o_row_data  = r_bank[r_rd_ptr];
    assign o_beat_cnt  = r_cnt;
    assign o_level     = r_level;

    assign w_accept   = i_valid & o_ready;
    assign w_pop      = o_row_valid & i_row_ready;
    // When both banks are full the fill bank is the presented bank, so a
    // restart there would destroy a completed row.
    assign w_start    = i_start & (r_level != 2'd2);
    assign w_slot     = w_start ? '0 : r_cnt;
    assign w_complete = w_accept & (w_slot == CNT_W'(BEATS - 1));
    assign w_order    = (w_slot == '0) ? i_lsb_first : r_order;
    // BEATS is a power of two, so BEATS-1-slot is the bitwise inverse.
    assign w_pos      = w_order ? w_slot : ~w_slot;

    // The fill bank and the popped bank never coincide: they are equal only
    // at level 0 (nothing to pop) or level 2 (nothing accepted, start blocked).
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bank_nxt[b] = r_bank[b];
            if (r_wr_ptr == 1'(b)) begin
                if (w_start) begin
                    w_bank_nxt[b] = '0;
                end
                if (w_accept) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (w_pos == CNT_W'(k)) begin
                            w_bank_nxt[b][k*DATA_W +: DATA_W] = i_data;
                        end
                    end
                end
            end
            if (w_pop && (r_rd_ptr == 1'(b))) begin
                w_bank_nxt[b] = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_cnt     <= '0;
            r_order   <= 1'b0;
            r_level   <= 2'd0;
        end else begin
            r_bank[0] <= w_bank_nxt[0];
            r_bank[1] <= w_bank_nxt[1];

            if (w_accept && (w_slot == '0)) begin
                r_order <= i_lsb_first;
            end

            if (w_complete) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= w_slot + CNT_W'(1);
            end else if (w_start) begin
                r_cnt <= '0;
            end

            if (w_complete) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_complete, w_pop})
                2'b10:   r_level <= r_level + 2'd1;
                2'b01:   r_level <= r_level - 2'd1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
